// File: rtl/aucohl_pwm_capture.sv
// aucohl_pwm_capture: input-capture unit measuring period/high/low time of cap_in in prescaled ticks.
// Optional glitch filter enabled by defining AUCOHL_CAP_FILTER_EN.
module aucohl_pwm_capture #(
  parameter int CNT_W   = 32,
  parameter int FLT_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cap_en,
  input  logic             cap_in,
  input  logic [31:0]      prescaler,
  input  logic [2:0]       cap_cfg,
  input  logic             cap_clr,
  output logic [CNT_W-1:0] cap_val,
  output logic             cap_done,
  output logic             cap_ovf,
  output logic             cap_busy
);
  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;
  state_t st_q, st_d;
  logic s1_q, s2_q, prev_q, en_q, sig;
  logic done_q, done_d, ovf_q, ovf_d;
  logic [31:0] pr_q, pr_d;
  logic [2:0] cfg_q, cfg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, val_q, val_d, inc;
  logic rise, fall, tick, sat, start, stop;
`ifdef AUCOHL_CAP_FILTER_EN
  localparam int FW = $clog2(FLT_LEN + 1);
  logic flt_q, flt_d;
  logic [FW-1:0] fc_q, fc_d;
  always_comb begin
    flt_d = flt_q;
    fc_d  = '0;
    if (s2_q != flt_q) begin
      fc_d = fc_q + FW'(1);
      if (fc_q == FW'(FLT_LEN - 1)) begin
        flt_d = s2_q;
        fc_d  = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      flt_q <= 1'b0;
      fc_q  <= '0;
    end else begin
      flt_q <= flt_d;
      fc_q  <= fc_d;
    end
  assign sig = flt_q;
`else
  assign sig = s2_q;
`endif
  assign rise  = sig & ~prev_q;
  assign fall  = ~sig & prev_q;
  assign tick  = (pr_q == 32'd0);
  assign pr_d  = (!cap_en || tick) ? prescaler : pr_q - 32'd1;
  assign start = cfg_q[1] ? fall : rise;
  assign stop  = cfg_q[0] ? fall : rise;
  assign sat   = (&cnt_q) & tick;
  assign inc   = sat ? cnt_q : cnt_q + CNT_W'(tick);
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    val_d  = val_q;
    cfg_d  = cfg_q;
    done_d = done_q & ~cap_clr;
    ovf_d  = ovf_q & ~cap_clr;
    if (!cap_en) st_d = IDLE;
    else
      case (st_q)
        IDLE: if (!en_q) begin
          st_d  = ARM;
          cfg_d = cap_cfg;
        end
        ARM: if (start) begin
          st_d  = MEAS;
          cnt_d = '0;
        end
        MEAS: begin
          cnt_d = inc;
          if (sat) ovf_d = 1'b1;
          if (stop) begin
            val_d  = inc;
            done_d = 1'b1;
            // modes 00/11 reuse the stop edge as the next start edge
            if (cfg_q[2]) st_d = IDLE;
            else if (cfg_q[1] == cfg_q[0]) cnt_d = '0;
            else st_d = ARM;
          end
        end
        default: st_d = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q   <= IDLE;
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
      en_q   <= 1'b0;
      pr_q   <= '0;
      cfg_q  <= '0;
      cnt_q  <= '0;
      val_q  <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      s1_q   <= cap_in;
      s2_q   <= s1_q;
      prev_q <= sig;
      en_q   <= cap_en;
      pr_q   <= pr_d;
      cfg_q  <= cfg_d;
      cnt_q  <= cnt_d;
      val_q  <= val_d;
      done_q <= done_d;
      ovf_q  <= ovf_d;
    end
  assign cap_val  = val_q;
  assign cap_done = done_q;
  assign cap_ovf  = ovf_q;
  assign cap_busy = (st_q != IDLE);
endmodule

// File: tb/tb_aucohl_pwm_capture.sv
// tb_aucohl_pwm_capture: directed scoreboard bench for the capture unit (CNT_W=8).
module tb_aucohl_pwm_capture;
  logic clk = 1'b0, rst_n = 1'b0, cap_en = 1'b0, cap_in = 1'b0, cap_clr = 1'b0;
  logic [31:0] prescaler = '0;
  logic [2:0] cap_cfg = '0;
  logic [7:0] cap_val;
  logic cap_done, cap_ovf, cap_busy;
  int tests = 0, fails = 0;
  int exp_q[$];
  aucohl_pwm_capture #(.CNT_W(8), .FLT_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .cap_en(cap_en), .cap_in(cap_in), .prescaler(prescaler),
    .cap_cfg(cap_cfg), .cap_clr(cap_clr), .cap_val(cap_val), .cap_done(cap_done),
    .cap_ovf(cap_ovf), .cap_busy(cap_busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic arm(input logic [2:0] cfg, input logic [31:0] pre);
    cap_en = 1'b0;
    cap_in = 1'b0;
    cap_cfg = cfg;
    prescaler = pre;
    cap_clr = 1'b1;
    @(negedge clk);
    cap_clr = 1'b0;
    repeat (4) @(negedge clk);
    cap_en = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic pwm(input int n, input int hi, input int lo);
    repeat (n) begin
      cap_in = 1'b1;
      repeat (hi) @(negedge clk);
      cap_in = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask
  task automatic check_cap(input string tag);
    int n = 0;
    int e;
    while (cap_done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    e = exp_q.pop_front();
    chk({tag, "_done"}, {31'd0, cap_done}, 32'd1);
    chk(tag, {24'd0, cap_val}, e);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_val", {24'd0, cap_val}, 0);
    chk("rst_done", {31'd0, cap_done}, 0);
    chk("rst_ovf", {31'd0, cap_ovf}, 0);
    chk("rst_busy", {31'd0, cap_busy}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    arm(3'b000, 0); exp_q.push_back(100); pwm(3, 30, 70); check_cap("t1_rr");
    chk("t1_ovf", {31'd0, cap_ovf}, 0);
    arm(3'b001, 0); exp_q.push_back(30); pwm(3, 30, 70); check_cap("t2_rf");
    chk("t2_rf_ovf", {31'd0, cap_ovf}, 0);
    arm(3'b010, 0); exp_q.push_back(70); pwm(3, 30, 70); check_cap("t2_fr");
    arm(3'b011, 0); exp_q.push_back(100); pwm(3, 30, 70); check_cap("t2_ff");
    arm(3'b000, 9); exp_q.push_back(100); pwm(2, 300, 700); check_cap("t3_pre9");
    arm(3'b100, 0); exp_q.push_back(100); pwm(3, 30, 70); check_cap("t4_one");
    chk("t4_busy", {31'd0, cap_busy}, 0);
    pwm(3, 15, 35);
    chk("t4_hold", {24'd0, cap_val}, 100);
    arm(3'b100, 0); exp_q.push_back(50); pwm(2, 15, 35); check_cap("t4_rearm");
    arm(3'b000, 0); exp_q.push_back(255); pwm(1, 100, 200);
    cap_in = 1'b1;
    repeat (10) @(negedge clk);
    check_cap("t5_sat");
    chk("t5_ovf", {31'd0, cap_ovf}, 1);
    cap_clr = 1'b1;
    @(negedge clk);
    cap_clr = 1'b0;
    chk("t5_clr_ovf", {31'd0, cap_ovf}, 0);
    chk("t5_clr_done", {31'd0, cap_done}, 0);
    chk("t5_busy_meas", {31'd0, cap_busy}, 1);
    cap_en = 1'b0;
    @(negedge clk);
    chk("t5_busy_drop", {31'd0, cap_busy}, 0);
    chk("t5_val_keep", {24'd0, cap_val}, 255);
    arm(3'b001, 0);
`ifdef AUCOHL_CAP_FILTER_EN
    pwm(1, 2, 30);
    chk("t6_flt_done", {31'd0, cap_done}, 0);
    chk("t6_flt_val", {24'd0, cap_val}, 255);
`else
    exp_q.push_back(2); pwm(1, 2, 30); check_cap("t6_glitch");
`endif
    arm(3'b000, 0);
    cap_in = 1'b1;
    repeat (8) @(negedge clk);
    chk("rst_mid_busy_pre", {31'd0, cap_busy}, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_val", {24'd0, cap_val}, 0);
    chk("rst_mid_busy", {31'd0, cap_busy}, 0);
    chk("rst_mid_done", {31'd0, cap_done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
